sparse_encoder: RTL and testbench

Sparse encoder that compresses a dense vector stream into the (index, value, last) entry stream consumed by the sparse MAC decoders. It drops zero-valued elements, tags each survivor with its position in the vector, and marks the final emitted entry of every vector. One instance sits in front of each decoder lane and drives its `sram_valid`/`sram_ready`/`sram_data` port.

---
 rtl/sparse_mac_pkg.sv | 31 +++
 rtl/sparse_enc_fifo.sv | 73 +++++++
 rtl/sparse_encoder.sv | 150 +++++++++++++++
 tb/tb_sparse_encoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sparse_mac_pkg.sv
// Shared types for the sparse MAC path: entry format, widths and the encoder FSM states.
package sparse_mac_pkg;

    localparam int VAL_W  = 8;
    localparam int IDX_W  = 6;

    typedef struct packed {
        logic [IDX_W-1:0]        idx;
        logic signed [VAL_W-1:0] val;
        logic                    last;
    } sram_data_t;

    localparam int SRAM_W = $bits(sram_data_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } enc_state_e;

    function automatic sram_data_t make_entry(input logic [IDX_W-1:0] idx,
                                              input logic signed [VAL_W-1:0] val,
                                              input logic last);
        sram_data_t ent;
        ent.idx  = idx;
        ent.val  = val;
        ent.last = last;
        return ent;
    endfunction

endpackage

// File: rtl/sparse_enc_fifo.sv
// Synchronous FIFO with registered full/empty flags; head reads as zero while empty.
module sparse_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_n_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? PTR_W'(0) : ptr + PTR_W'(1);
    endfunction

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign head      = empty_r ? WIDTH'(0) : mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop, used to register the flags.
    always_comb begin
        count_n_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_n_s = count_r + CNT_W'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_n_s = count_r - CNT_W'(1);
        end else begin
            count_n_s = count_r;
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
            count_r <= count_n_s;
            full_r  <= (count_n_s == CNT_W'(DEPTH));
            empty_r <= (count_n_s == CNT_W'(0));
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/sparse_encoder.sv
// Dense-to-sparse encoder: drops zeros, tags survivors with their index, marks vector end.
// Optional SPARSE_ENC_STATS_EN adds per-vector nonzero count outputs.
module sparse_encoder
    import sparse_mac_pkg::*;
#(
    parameter int VEC_LEN    = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    mac_clk,
    input  logic                    mac_rst,
    input  logic                    dense_valid_i,
    output logic                    dense_ready_o,
    input  logic signed [VAL_W-1:0] dense_val_i,
    input  logic                    dense_last_i,
    output logic                    sram_valid_o,
    input  logic                    sram_ready_i,
    output sram_data_t              sram_data_o
`ifdef SPARSE_ENC_STATS_EN
    ,
    output logic [IDX_W:0]          stat_nnz_o,
    output logic                    stat_valid_o
`endif
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    enc_state_e       state_r;
    enc_state_e       state_n_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_n_s;
    sram_data_t       pend_r;
    sram_data_t       pend_n_s;
    sram_data_t       push_data_s;
    sram_data_t       fifo_head_s;
    logic             push_s;
    logic             accept_s;
    logic             is_zero_s;
    logic             is_end_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    // Ready uses only registered state so a full-FIFO pop never admits a same-cycle push.
    assign dense_ready_o = !mac_rst && (state_r != ST_FLUSH) && !fifo_full_s;
    assign accept_s      = dense_valid_i && dense_ready_o;
    assign is_zero_s     = (dense_val_i == VAL_W'(0));
    assign is_end_s      = dense_last_i || (idx_r == LAST_IDX);
    assign sram_valid_o  = !fifo_empty_s;
    assign sram_data_o   = fifo_head_s;

    // Next-state, pending-slot and push decision.
    always_comb begin
        state_n_s   = state_r;
        pend_n_s    = pend_r;
        idx_n_s     = idx_r;
        push_s      = 1'b0;
        push_data_s = pend_r;
        if (accept_s) begin
            idx_n_s = is_end_s ? IDX_W'(0) : idx_r + IDX_W'(1);
            case (state_r)
                ST_EMPTY: begin
                    if (is_zero_s) begin
                        if (is_end_s) begin
                            push_s      = 1'b1;
                            push_data_s = make_entry(IDX_W'(0), VAL_W'(0), 1'b1);
                        end else begin
                            push_s = 1'b0;
                        end
                    end else if (is_end_s) begin
                        push_s      = 1'b1;
                        push_data_s = make_entry(idx_r, dense_val_i, 1'b1);
                    end else begin
                        pend_n_s  = make_entry(idx_r, dense_val_i, 1'b0);
                        state_n_s = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (is_zero_s) begin
                        if (is_end_s) begin
                            push_s      = 1'b1;
                            push_data_s = make_entry(pend_r.idx, pend_r.val, 1'b1);
                            state_n_s   = ST_EMPTY;
                        end else begin
                            push_s = 1'b0;
                        end
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = make_entry(pend_r.idx, pend_r.val, 1'b0);
                        pend_n_s    = make_entry(idx_r, dense_val_i, is_end_s);
                        state_n_s   = is_end_s ? ST_FLUSH : ST_PEND;
                    end
                end
                default: begin
                    state_n_s = ST_EMPTY;
                end
            endcase
        end else if ((state_r == ST_FLUSH) && !fifo_full_s) begin
            push_s      = 1'b1;
            push_data_s = make_entry(pend_r.idx, pend_r.val, 1'b1);
            state_n_s   = ST_EMPTY;
        end else begin
            push_s = 1'b0;
        end
    end

    // State, index counter and pending register.
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            state_r <= ST_EMPTY;
            idx_r   <= IDX_W'(0);
            pend_r  <= make_entry(IDX_W'(0), VAL_W'(0), 1'b0);
        end else begin
            state_r <= state_n_s;
            idx_r   <= idx_n_s;
            pend_r  <= pend_n_s;
        end
    end

    sparse_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SRAM_W)
    ) u_fifo (
        .clk       (mac_clk),
        .rst       (mac_rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (sram_ready_i),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

`ifdef SPARSE_ENC_STATS_EN
    localparam int NNZ_W = IDX_W + 1;
    logic [NNZ_W-1:0] nnz_r;
    logic [NNZ_W-1:0] nnz_now_s;

    assign nnz_now_s    = nnz_r + ((accept_s && !is_zero_s) ? NNZ_W'(1) : NNZ_W'(0));
    assign stat_valid_o = accept_s && is_end_s;
    assign stat_nnz_o   = stat_valid_o ? nnz_now_s : NNZ_W'(0);

    // Running nonzero count for the current vector.
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            nnz_r <= NNZ_W'(0);
        end else if (accept_s) begin
            nnz_r <= is_end_s ? NNZ_W'(0) : nnz_now_s;
        end
    end
`endif

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed bench for sparse_encoder with VEC_LEN=8, FIFO_DEPTH=2.
module tb_sparse_encoder;
    import sparse_mac_pkg::*;

    logic                    mac_clk = 1'b0;
    logic                    mac_rst = 1'b1;
    logic                    dense_valid_i = 1'b0;
    logic                    dense_ready_o;
    logic signed [VAL_W-1:0] dense_val_i = '0;
    logic                    dense_last_i = 1'b0;
    logic                    sram_valid_o;
    logic                    sram_ready_i = 1'b1;
    sram_data_t              sram_data_o;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    sram_data_t        got_q[$];
    logic [SRAM_W-1:0] exp_q[$];

`ifdef SPARSE_ENC_STATS_EN
    logic [IDX_W:0] stat_nnz_o;
    logic           stat_valid_o;
    int             stat_pulses = 0;
    logic [IDX_W:0] stat_last = '0;
`endif

    sparse_encoder #(.VEC_LEN(8), .FIFO_DEPTH(2)) dut (
        .mac_clk       (mac_clk),
        .mac_rst       (mac_rst),
        .dense_valid_i (dense_valid_i),
        .dense_ready_o (dense_ready_o),
        .dense_val_i   (dense_val_i),
        .dense_last_i  (dense_last_i),
        .sram_valid_o  (sram_valid_o),
        .sram_ready_i  (sram_ready_i),
        .sram_data_o   (sram_data_o)
`ifdef SPARSE_ENC_STATS_EN
        ,
        .stat_nnz_o    (stat_nnz_o),
        .stat_valid_o  (stat_valid_o)
`endif
    );

    always #5 mac_clk = ~mac_clk;

    // Capture every entry the decoder side accepts.
    always @(negedge mac_clk) begin
        if (!mac_rst && sram_valid_o && sram_ready_i) got_q.push_back(sram_data_o);
    end

`ifdef SPARSE_ENC_STATS_EN
    always @(negedge mac_clk) begin
        if (stat_valid_o) begin
            stat_pulses++;
            stat_last = stat_nnz_o;
        end
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [SRAM_W-1:0] e(input int idx, input int val, input bit last);
        return {IDX_W'(idx), VAL_W'(val), last};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mac_clk);
        #1;
    endtask

    task automatic send(input int v, input bit l);
        bit done = 1'b0;
        dense_valid_i = 1'b1;
        dense_val_i   = VAL_W'(v);
        dense_last_i  = l;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge mac_clk);
            done = dense_ready_o;
            if (!done) stalls++;
            cyc();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout observed=stalled expected=accepted");
        end
    endtask

    task automatic idle(input int n);
        dense_valid_i = 1'b0;
        dense_last_i  = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_entry"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_valid", 32'(sram_valid_o), 32'd0);
        chk("rst_data", 32'(sram_data_o), 32'd0);
        chk("rst_ready", 32'(dense_ready_o), 32'd0);
        mac_rst = 1'b0;
        cyc();
        chk("post_rst_ready", 32'(dense_ready_o), 32'd1);

        // Vector with scattered nonzeros, last on a zero element
        send(0, 0); send(5, 0); send(0, 0); send(0, 0);
        send(-3, 0); send(0, 0); send(7, 0); send(0, 1);
        chk("v1_no_stall", 32'(stalls), 32'd0);
        idle(4);
        exp_q.push_back(e(1, 5, 0));
        exp_q.push_back(e(4, -3, 0));
        exp_q.push_back(e(6, 7, 1));
        check_q("v1");
`ifdef SPARSE_ENC_STATS_EN
        chk("stat_pulses", 32'(stat_pulses), 32'd1);
        chk("stat_nnz", 32'(stat_last), 32'd3);
`endif

        // All-zero vector
        send(0, 0); send(0, 0); send(0, 0); send(0, 1);
        idle(3);
        exp_q.push_back(e(0, 0, 1));
        check_q("zero_vec");

        // Nonzero last element costs one FLUSH cycle
        send(1, 0);
        send(2, 1);
        chk("flush_ready_low", 32'(dense_ready_o), 32'd0);
        idle(1);
        chk("flush_ready_back", 32'(dense_ready_o), 32'd1);
        idle(3);
        exp_q.push_back(e(0, 1, 0));
        exp_q.push_back(e(1, 2, 1));
        check_q("flush_vec");

        // Forced last at VEC_LEN-1, then a new vector starts at idx 0
        send(9, 0);
        for (int i = 0; i < 6; i++) send(0, 0);
        send(4, 0);
        send(6, 1);
        idle(4);
        exp_q.push_back(e(0, 9, 0));
        exp_q.push_back(e(7, 4, 1));
        exp_q.push_back(e(0, 6, 1));
        check_q("forced_last");

        // Backpressure: FIFO fills, input stalls, head stays stable
        sram_ready_i = 1'b0;
        send(1, 0); send(2, 0); send(3, 0);
        chk("bp_full_ready", 32'(dense_ready_o), 32'd0);
        dense_valid_i = 1'b1;
        dense_val_i   = VAL_W'(4);
        dense_last_i  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_ready", 32'(dense_ready_o), 32'd0);
            chk("bp_valid", 32'(sram_valid_o), 32'd1);
            chk("bp_head", 32'(sram_data_o), 32'(e(0, 1, 0)));
        end
        sram_ready_i = 1'b1;
        send(4, 0);
        send(5, 1);
        idle(6);
        exp_q.push_back(e(0, 1, 0));
        exp_q.push_back(e(1, 2, 0));
        exp_q.push_back(e(2, 3, 0));
        exp_q.push_back(e(3, 4, 0));
        exp_q.push_back(e(4, 5, 1));
        check_q("backpressure");

        // Reset while PEND with a full FIFO discards everything
        sram_ready_i = 1'b0;
        send(1, 0); send(2, 0); send(3, 0);
        dense_valid_i = 1'b0;
        mac_rst = 1'b1;
        chk("midrst_ready", 32'(dense_ready_o), 32'd0);
        cyc();
        chk("midrst_valid", 32'(sram_valid_o), 32'd0);
        chk("midrst_data", 32'(sram_data_o), 32'd0);
        mac_rst = 1'b0;
        sram_ready_i = 1'b1;
        got_q.delete();
        send(3, 1);
        idle(4);
        exp_q.push_back(e(0, 3, 1));
        check_q("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
